hellorld_rx: RTL
================

# hellorld_rx

Serial receiver for the 8N1 byte stream produced by the hellorld transmitter in the misc tile. It is the receiving end of that serial link, clocked from the same `clk_i` and sharing its clocks-per-bit divisor convention (1040 in the tile). It delivers each received byte over a valid/ready handshake to an on-chip consumer such as a nano peripheral slot or a loopback checker. Framing errors and overruns are reported as single-cycle pulses.

## Interface
Parameters:
- `DIV_W`, default 16: width of the divisor input.

Ports:
- `clk_i`, in, 1: sole clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `rx_i`, in, 1: serial line, asynchronous to `clk_i`, idle high.
- `divisor`, in, DIV_W: clock cycles per bit. Values below 4 are treated as 4.
- `data_o`, out, 8: received byte. Stable while `valid_o` is high.
- `valid_o`, out, 1: byte available.
- `ready_i`, in, 1: consumer accepts the byte. A transfer occurs on any cycle where `valid_o` and `ready_i` are both high.
- `busy_o`, out, 1: high in every state except IDLE.
- `frame_err_o`, out, 1: one-cycle pulse when the stop bit is sampled low.
- `overrun_o`, out, 1: one-cycle pulse when a completed byte is dropped.

## Operation
- `rx_i` passes through a 2-flop synchronizer to give `rx_s`. The FSM uses only `rx_s`.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - On `rx_s`==0, latch `max(divisor,4)` into `div_q`, clear the bit counter and the cycle counter, and go to START.
  - `divisor` changes during a frame are ignored.
- START:
  - Sample `rx_s` `div_q>>1` cycles after entry.
  - If it is 1 (false start), go to IDLE with no flags.
  - If it is 0, go to DATA.
- DATA:
  - Sample every `div_q` cycles after the previous sample.
  - Shift the sample into the shift register LSB-first.
  - After 8 samples, go to STOP.
- STOP: sample `div_q` cycles after the last data sample.
  - Sample is 1, output register empty, or empty this cycle because `ready_i` is high: load `data_o` from the shift register, set `valid_o`, go to IDLE.
  - Sample is 1 and output register still full: drop the new byte, pulse `overrun_o`, keep the old `data_o`/`valid_o`, go to IDLE.
  - Sample is 0: pulse `frame_err_o`, deliver nothing, go to WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s`==1 (this also covers a line break), then go to IDLE.
- Output register:
  - `valid_o` clears on the transfer cycle unless a new byte loads in the same cycle; in that case it stays high with the new data.
  - `data_o` holds its last value after a transfer.
- Reset values: state IDLE, all counters 0, `data_o`=8'h00, `valid_o`=0, `busy_o`=0, `frame_err_o`=0, `overrun_o`=0, synchronizer flops 1.
- Asserting `rst` mid-frame aborts the frame immediately. Any partial byte is discarded and no flags are raised.

## Timing
- Let the detection cycle D be the cycle IDLE sees `rx_s`==0. D is 2–3 cycles after the falling edge on `rx_i`.
- Start sample at D + `div_q>>1`.
- Data bit k (k=0..7) sampled at D + `div_q>>1` + (k+1)·`div_q`.
- Stop sampled at D + `div_q>>1` + 9·`div_q`.
- `valid_o`, `frame_err_o` and `overrun_o` assert on the cycle after the stop sample.
- The FSM returns to IDLE on that same cycle, so back-to-back frames with a one-bit stop are received without loss.
- Counter widths: cycle counter DIV_W bits, bit counter 3 bits. No wrap occurs within a frame, because the counter is compared against `div_q-1`.

## Structure
- Package `hellorld_rx_pkg` holds:
  - the state encoding (IDLE..WAIT_IDLE);
  - `MIN_DIV` = 4;
  - `TILE_DIV` = 1040.
- Sub-module `rx_sync`: a 2-flop synchronizer with async reset to 1. Everything else is in a single module.

## Test plan
- Divisor 16, send 0x48 with `ready_i` high → `valid_o` for 1 cycle with `data_o`=0x48, at D+8+9·16+1; `busy_o` low afterwards.
- Divisor 1040, send "Hellorld" back-to-back, `ready_i` high → 8 transfers in order 0x48 0x65 0x6C 0x6C 0x6F 0x72 0x6C 0x64, no flags.
- Divisor 16, send 0x55 then 0xAA with `ready_i` low → `data_o` stays 0x55, `overrun_o` pulses once at the end of 0xAA; after raising `ready_i`, exactly 1 transfer occurs.
- Divisor 16, 0x3C with the stop bit forced low for 2 bit-times → `frame_err_o` pulses once, no `valid_o`; the next 0x3C is received correctly.
- Divisor 16, low glitch of 5 cycles → return to IDLE, no flags, no `valid_o`; divisor 2 → behaves as 4.
- Assert `rst` during data bit 4 of 0xF0 → all outputs at reset values; the next frame 0x0F is received correctly.

Source files
------------

// File: rtl/hellorld_rx_pkg.sv
// Shared definitions for the hellorld serial receiver: FSM encoding and
// divisor constants matching the hellorld transmitter.
package hellorld_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } rx_state_t;

  localparam int MIN_DIV  = 4;
  localparam int TILE_DIV = 1040;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle-high level so no spurious start bit is seen after reset.
module rx_sync (
  input  logic clk_i,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/hellorld_rx.sv
// 8N1 serial receiver: mid-bit sampling FSM feeding a one-entry output
// register with a valid/ready handshake, plus framing/overrun pulses.
module hellorld_rx
  import hellorld_rx_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             rx_i,
  input  logic [DIV_W-1:0] divisor,
  output logic [7:0]       data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             frame_err_o,
  output logic             overrun_o
);

  logic rx_s;

  rx_sync u_rx_sync (
    .clk_i (clk_i),
    .rst   (rst),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  rx_state_t        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic [DIV_W-1:0] half_m1;
  logic [DIV_W-1:0] full_m1;

  // Counter restarts at 0 on each sample, so cnt == N-1 marks N cycles elapsed.
  assign half_m1 = (div_q >> 1) - 1'b1;
  assign full_m1 = div_q - 1'b1;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q && !ready_i;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          div_d   = (divisor < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : divisor;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == half_m1) begin
          cnt_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == full_m1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == full_m1) begin
          cnt_d = '0;
          if (rx_s) begin
            // A byte leaving this cycle frees the register for the new one.
            if (!valid_q || ready_i) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign busy_o      = (state_q != S_IDLE);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule
